// File: rtl/apple1_mem_pkg.sv
// apple1_mem_pkg: shared FSM encodings and port ids for the arbitrated system RAM
package apple1_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/ram_sp_array.sv
// ram_sp_array: inferred single-port block RAM, read-first, one-cycle registered read
module ram_sp_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 49152,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
endmodule

// File: rtl/ram_arb.sv
// ram_arb: single-port system RAM shared by two req/ack masters with round-robin
// arbitration, out-of-range masking and a power-on clear sequencer
module ram_arb import apple1_mem_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 49152,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_dout,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_dout,
  output logic              init_busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
  state_t state, state_nx;
  logic [AW-1:0] cnt, addr;
  logic ptr, oor_q, clear, a_in, b_in, a_el, b_el, gnt_a, gnt_b, en, we;
  logic [DATA_W-1:0] din, arr_dout, rd, a_hold, b_hold;
  ram_sp_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk), .en(en), .we(we), .addr(addr), .din(din), .dout(arr_dout)
  );
  always_comb begin
    clear = state == ST_CLEAR;
    a_in = {1'b0, a_addr} < LIMIT;
    b_in = {1'b0, b_addr} < LIMIT;
    a_el = !clear && a_req && !a_ack;
    b_el = !clear && b_req && !b_ack;
    gnt_a = a_el && (!b_el || ptr == PORT_A);
    gnt_b = b_el && !gnt_a;
    en = clear || gnt_a || gnt_b;
    we = clear || (gnt_a ? a_we && a_in : b_we && b_in);
    addr = clear ? cnt : gnt_a ? a_addr[AW-1:0] : b_addr[AW-1:0];
    din = clear ? CLEAR_VALUE : gnt_a ? a_din : b_din;
    state_nx = clear && cnt == AW'(DEPTH - 1) ? ST_SERVE : state;
    rd = oor_q ? '0 : arr_dout;
  end
  // ptr names the port that wins the next contested cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
      cnt <= '0;
      ptr <= PORT_A;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      oor_q <= 1'b0;
      a_hold <= '0;
      b_hold <= '0;
    end else begin
      state <= state_nx;
      if (clear) cnt <= cnt + AW'(1);
      if (a_el && b_el) ptr <= gnt_a ? PORT_B : PORT_A;
      a_ack <= gnt_a;
      b_ack <= gnt_b;
      oor_q <= gnt_a ? !a_in : !b_in;
      if (a_ack) a_hold <= rd;
      if (b_ack) b_hold <= rd;
    end
  assign a_dout = a_ack ? rd : a_hold;
  assign b_dout = b_ack ? rd : b_hold;
  assign init_busy = state == ST_CLEAR;
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: randomized two-master traffic checked every cycle against a behavioural model
module tb_ram_arb;
  localparam int DW = 8, AW = 16, DEPTH = 16;
  logic clk = 0, rst_n = 0;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = 0, b_addr = 0;
  logic [DW-1:0] a_din = 0, b_din = 0;
  logic a_ack, b_ack, init_busy;
  logic [DW-1:0] a_dout, b_dout;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;

  ram_arb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack), .a_dout(a_dout),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack), .b_dout(b_dout),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: memory image, clear cycles left, expected acks and held read data
  logic [DW-1:0] mm [DEPTH];
  int clr_left = DEPTH, last_win = 1, win;
  bit ea = 0, eb = 0, ela, elb;
  logic [DW-1:0] eda = 0, edb = 0, old;
  logic [AW-1:0] ad;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clr_left = DEPTH; ea = 0; eb = 0; eda = 0; edb = 0; last_win = 1;
    end else if (clr_left > 0) begin
      mm[DEPTH - clr_left] = 8'h00;
      clr_left--;
    end else begin
      ela = a_req && !ea;
      elb = b_req && !eb;
      win = (ela && elb) ? 1 - last_win : ela ? 0 : elb ? 1 : -1;
      if (ela && elb) last_win = win;
      ea = win == 0;
      eb = win == 1;
      if (win >= 0) begin
        ad = win == 1 ? b_addr : a_addr;
        old = ad < DEPTH ? mm[ad[3:0]] : 8'h00;
        if ((win == 1 ? b_we : a_we) && ad < DEPTH) mm[ad[3:0]] = win == 1 ? b_din : a_din;
        if (win == 1) edb = old; else eda = old;
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      check("a_ack", a_ack, ea);
      check("b_ack", b_ack, eb);
      check("init_busy", init_busy, clr_left > 0);
      check("a_dout", a_dout, eda);
      check("b_dout", b_dout, edb);
    end

  task automatic acc(input bit p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     output logic [DW-1:0] q, output int lat);
    if (p) begin b_req = 1; b_we = we; b_addr = a; b_din = d; end
    else begin a_req = 1; a_we = we; a_addr = a; a_din = d; end
    lat = 0;
    do begin @(negedge clk); lat++; end while (!(p ? b_ack : a_ack) && lat < 100);
    if (!(p ? b_ack : a_ack)) begin
      compared++; mismatched++;
      $display("FAIL ack_timeout port %0d: no ack after %0d cycles, required an ack", p, lat);
    end
    q = p ? b_dout : a_dout;
    if (p) b_req = 0; else a_req = 0;
  endtask

  task automatic release_and_count(output int n);
    rst_n = 1;
    n = init_busy ? 1 : 0;
    while (init_busy && n < 100) begin
      @(negedge clk);
      if (init_busy) n++;
    end
  endtask

  task automatic master(input bit p);
    logic [DW-1:0] q;
    logic [AW-1:0] a;
    int lat, r;
    repeat (120) begin
      r = $urandom_range(0, 9);
      a = r < 8 ? 16'($urandom_range(0, 15)) : r == 8 ? 16'(16 + $urandom_range(0, 3))
                : 16'(16'hFFFF - $urandom_range(0, 2));
      acc(p, 1'($urandom_range(0, 1)), a, 8'($urandom), q, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    logic [DW-1:0] q;
    int lat, n, na, nb, alt, bad;
    logic pa;
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_busy", init_busy, 1);
    check("rst_a_dout", a_dout, 0);
    release_and_count(n);
    check("clear_cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) begin
      acc(1'(i % 2), 0, 16'(i), 0, q, lat);
      check("cleared_word", q, 0);
    end
    @(negedge clk);
    acc(0, 1, 16'h0003, 8'h5A, q, lat);
    check("wr_old_data", q, 0);
    check("wr_latency", lat, 1);
    acc(0, 0, 16'h0003, 0, q, lat);
    check("rd_data", q, 8'h5A);
    check("rd_b2b_latency", lat, 2);
    a_addr = 10; a_we = 0; b_addr = 12; b_we = 0;
    a_req = 1; b_req = 1; na = 0; nb = 0; alt = 0; pa = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      na += int'(a_ack);
      nb += int'(b_ack);
      if (a_ack != b_ack && (i == 0 || a_ack != pa)) alt++;
      pa = a_ack;
    end
    a_req = 0; b_req = 0;
    check("rr_a_acks", na, 6);
    check("rr_b_acks", nb, 6);
    check("rr_alternate", alt, 12);
    @(negedge clk);
    acc(1, 1, 16'd16, 8'hFF, q, lat);
    check("oor_wr_latency", lat, 1);
    check("oor_wr_dout", q, 0);
    acc(1, 1, 16'hC000, 8'hFF, q, lat);
    check("oor_wr2_latency", lat, 2);
    acc(0, 0, 16'd16, 0, q, lat);
    check("oor_rd", q, 0);
    acc(0, 0, 16'hC000, 0, q, lat);
    check("oor_rd_c000", q, 0);
    acc(0, 0, 16'h0003, 0, q, lat);
    check("inrange_kept", q, 8'h5A);
    acc(1, 0, 16'h0000, 0, q, lat);
    check("inrange_zero", q, 0);
    fork
      master(0);
      master(1);
    join
    repeat (2) @(negedge clk);
    acc(0, 1, 16'h0005, 8'hC3, q, lat);
    acc(0, 0, 16'h0005, 0, q, lat);
    check("pre_reset_rd", q, 8'hC3);
    @(posedge clk); #1 rst_n = 0; #1;
    check("reset_a_dout", a_dout, 0);
    check("reset_busy", init_busy, 1);
    @(negedge clk);
    rst_n = 1;
    repeat (7) @(posedge clk);
    #1 rst_n = 0; #1;
    check("midclr_a_ack", a_ack, 0);
    check("midclr_b_ack", b_ack, 0);
    check("midclr_busy", init_busy, 1);
    check("midclr_b_dout", b_dout, 0);
    @(negedge clk);
    release_and_count(n);
    check("restart_clear_cycles", n, 16);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0005;
    rst_n = 1; n = 0; bad = 0;
    while (init_busy && n < 100) begin
      if (a_ack) bad++;
      @(negedge clk);
      n++;
    end
    check("pend_no_ack", bad, 0);
    check("pend_wait", n, 16);
    check("pend_ack_first_serve", a_ack, 0);
    @(negedge clk);
    check("pend_ack", a_ack, 1);
    check("pend_dout", a_dout, 0);
    a_req = 0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
